// File: rtl/constants_pkg.sv
// Shared core-stage encoding, trace-entry layout and compare helper used by the
// execution trace checker and its FIFO.
package constants_pkg;

    typedef enum logic [2:0] {
        STAGE_RESET       = 3'd0,
        INSTR_FETCH_START = 3'd1,
        INSTR_FETCH_WAIT  = 3'd2,
        INSTR_DECODE      = 3'd3,
        INSTR_EXECUTE     = 3'd4,
        MEM_ACCESS        = 3'd5,
        WRITE_BACK        = 3'd6,
        HALTED            = 3'd7
    } ExecutionStage;

    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic [63:0] regs;
        logic [7:0]  mask;
    } trace_entry_t;

    typedef enum logic {
        CHK_IDLE = 1'b0,
        CHK_CMP  = 1'b1
    } chk_state_t;

    // Bit i flags register ri; r0 occupies the most significant byte.
    function automatic logic [NUM_REGS-1:0] masked_diff(input logic [63:0] cap,
                                                       input logic [63:0] expv,
                                                       input logic [7:0]  mask);
        logic [NUM_REGS-1:0] d;
        d = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            d[i] = mask[i] & (cap[63-8*i -: 8] != expv[63-8*i -: 8]);
        end
        return d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; the head entry is visible on rdata_o
// whenever the FIFO is not empty.
module sync_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (level_q == LVL_FULL);
    assign empty_o   = (level_q == {LW{1'b0}});
    assign level_o   = level_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; pointer arithmetic wraps naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/execution_trace_checker.sv
// Pops an expected register snapshot at each fetch start and compares it one
// cycle later against the captured live registers under a per-register mask.
module execution_trace_checker
    import constants_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  ExecutionStage          state,
    input  logic [7:0]             r0,
    input  logic [7:0]             r1,
    input  logic [7:0]             r2,
    input  logic [7:0]             r3,
    input  logic [7:0]             r4,
    input  logic [7:0]             r5,
    input  logic [7:0]             r6,
    input  logic [7:0]             r7,
    input  logic                   exp_valid,
    output logic                   exp_ready,
    input  logic [63:0]            exp_regs,
    input  logic [7:0]             exp_mask,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       checked_count,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic [CNT_W-1:0]       underflow_count,
    output logic                   mismatch,
    output logic [7:0]             mismatch_regs,
    output logic                   first_mismatch_valid,
    output logic [CNT_W-1:0]       first_mismatch_index
);
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ExecutionStage  prev_state_q;
    chk_state_t     chk_state_q, chk_state_d;
    logic [63:0]    cap_q, cap_d;
    trace_entry_t   ent_q, ent_d;
    logic [CNT_W-1:0] checked_q, checked_d, mcnt_q, mcnt_d, under_q, under_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic           mismatch_q, mismatch_d, fv_q, fv_d;
    logic [7:0]     mregs_q, mregs_d;

    trace_entry_t   fifo_head_s;
    trace_entry_t   fifo_wdata_s;
    logic           fifo_full_s, fifo_empty_s;
    logic           trigger_s, pop_s, push_s;
    logic [NUM_REGS-1:0] diff_s;

    assign trigger_s    = enable && (state == INSTR_FETCH_START) && (prev_state_q != INSTR_FETCH_START);
    assign pop_s        = trigger_s & ~fifo_empty_s;
    assign exp_ready    = ~fifo_full_s;
    assign push_s       = exp_valid & exp_ready;
    assign fifo_wdata_s = '{regs: exp_regs, mask: exp_mask};
    assign diff_s       = masked_diff(cap_q, ent_q.regs, ent_q.mask);

    sync_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level)
    );

    // A new capture may land on the compare edge, so CMP is re-entered on any pop.
    always_comb begin
        chk_state_d = pop_s ? CHK_CMP : CHK_IDLE;
        cap_d       = pop_s ? {r0, r1, r2, r3, r4, r5, r6, r7} : cap_q;
        ent_d       = pop_s ? fifo_head_s : ent_q;
        under_d     = (trigger_s && fifo_empty_s) ? sat_inc(under_q) : under_q;
        checked_d   = checked_q;
        mcnt_d      = mcnt_q;
        mismatch_d  = 1'b0;
        mregs_d     = mregs_q;
        fv_d        = fv_q;
        fidx_d      = fidx_q;
        if (chk_state_q == CHK_CMP) begin
            checked_d = sat_inc(checked_q);
            mregs_d   = diff_s;
            if (|diff_s) begin
                mismatch_d = 1'b1;
                mcnt_d     = sat_inc(mcnt_q);
                if (!fv_q) begin
                    fv_d   = 1'b1;
                    fidx_d = checked_q;
                end else begin
                    fidx_d = fidx_q;
                end
            end else begin
                mismatch_d = 1'b0;
            end
        end else begin
            checked_d = checked_q;
        end
    end

    // State, capture and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_state_q <= STAGE_RESET;
            chk_state_q  <= CHK_IDLE;
            cap_q        <= 64'h0;
            ent_q        <= '0;
            checked_q    <= {CNT_W{1'b0}};
            mcnt_q       <= {CNT_W{1'b0}};
            under_q      <= {CNT_W{1'b0}};
            mismatch_q   <= 1'b0;
            mregs_q      <= 8'h00;
            fv_q         <= 1'b0;
            fidx_q       <= {CNT_W{1'b0}};
        end else begin
            prev_state_q <= state;
            chk_state_q  <= chk_state_d;
            cap_q        <= cap_d;
            ent_q        <= ent_d;
            checked_q    <= checked_d;
            mcnt_q       <= mcnt_d;
            under_q      <= under_d;
            mismatch_q   <= mismatch_d;
            mregs_q      <= mregs_d;
            fv_q         <= fv_d;
            fidx_q       <= fidx_d;
        end
    end

    assign checked_count        = checked_q;
    assign mismatch_count       = mcnt_q;
    assign underflow_count      = under_q;
    assign mismatch             = mismatch_q;
    assign mismatch_regs        = mregs_q;
    assign first_mismatch_valid = fv_q;
    assign first_mismatch_index = fidx_q;

endmodule

// File: tb/tb_execution_trace_checker.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_execution_trace_checker;
    import constants_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam logic [63:0] BASE = 64'h0001020304050607;

    logic          clk = 1'b0;
    logic          reset, enable, exp_valid, exp_ready;
    ExecutionStage state;
    logic [7:0]    rv [8];
    logic [63:0]   exp_regs;
    logic [7:0]    exp_mask;
    logic [4:0]    fifo_level;
    logic [15:0]   checked_count, mismatch_count, underflow_count, first_mismatch_index;
    logic          mismatch, first_mismatch_valid;
    logic [7:0]    mismatch_regs;

    int total = 0;
    int bad   = 0;
    int pulses;

    typedef struct { logic [63:0] regs; logic [7:0] mask; } ent_t;
    ent_t          m_q [$];
    logic [15:0]   m_checked, m_mcnt, m_under, m_fidx;
    bit            m_mis, m_fv, m_pend;
    logic [7:0]    m_mregs;
    logic [63:0]   m_pcap;
    ent_t          m_pent;
    ExecutionStage m_prev;

    always #5 clk = ~clk;

    execution_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .state(state),
        .r0(rv[0]), .r1(rv[1]), .r2(rv[2]), .r3(rv[3]),
        .r4(rv[4]), .r5(rv[5]), .r6(rv[6]), .r7(rv[7]),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_regs(exp_regs), .exp_mask(exp_mask),
        .fifo_level(fifo_level), .checked_count(checked_count), .mismatch_count(mismatch_count),
        .underflow_count(underflow_count), .mismatch(mismatch), .mismatch_regs(mismatch_regs),
        .first_mismatch_valid(first_mismatch_valid), .first_mismatch_index(first_mismatch_index)
    );

    function automatic logic [63:0] live_regs();
        return {rv[0], rv[1], rv[2], rv[3], rv[4], rv[5], rv[6], rv[7]};
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reference model: what the block should hold after the coming clock edge.
    function automatic void model_edge();
        logic [7:0] d;
        bit trig;
        int sz;
        if (reset) begin
            m_q.delete();
            m_checked = 16'd0; m_mcnt = 16'd0; m_under = 16'd0; m_fidx = 16'd0;
            m_mis = 1'b0; m_fv = 1'b0; m_pend = 1'b0; m_mregs = 8'h00;
            m_prev = STAGE_RESET;
            return;
        end
        sz   = m_q.size();
        trig = enable && (state == INSTR_FETCH_START) && (m_prev != INSTR_FETCH_START);
        m_mis = 1'b0;
        if (m_pend) begin
            d = 8'h00;
            for (int i = 0; i < 8; i++)
                if (m_pent.mask[i] && (m_pcap[8*(7-i) +: 8] != m_pent.regs[8*(7-i) +: 8])) d[i] = 1'b1;
            m_mregs = d;
            if (d != 8'h00) begin
                m_mis  = 1'b1;
                m_mcnt = sat(m_mcnt);
                if (!m_fv) begin m_fv = 1'b1; m_fidx = m_checked; end
            end
            m_checked = sat(m_checked);
        end
        m_pend = 1'b0;
        if (trig) begin
            if (sz > 0) begin
                m_pend = 1'b1;
                m_pcap = live_regs();
                m_pent = m_q.pop_front();
            end else begin
                m_under = sat(m_under);
            end
        end
        if (exp_valid && (sz != DEPTH)) m_q.push_back('{regs: exp_regs, mask: exp_mask});
        m_prev = state;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (mismatch === 1'b1) pulses++;
    endtask

    task automatic apply_reset();
        reset = 1'b1; exp_valid = 1'b0; state = INSTR_DECODE;
        step(); step();
        reset = 1'b0;
        pulses = 0;
    endtask

    task automatic push_entry(input logic [63:0] r, input logic [7:0] m);
        exp_valid = 1'b1; exp_regs = r; exp_mask = m;
        step();
        exp_valid = 1'b0;
    endtask

    task automatic do_fetch(input int cycles);
        state = INSTR_FETCH_START;
        repeat (cycles) step();
        state = INSTR_DECODE;
        step(); step();
    endtask

    task automatic set_live(input logic [63:0] v);
        for (int i = 0; i < 8; i++) rv[i] = v[8*(7-i) +: 8];
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({checked_count, mismatch_count, underflow_count, first_mismatch_index, mismatch_regs,
             mismatch, first_mismatch_valid, fifo_level} !== 79'd0) begin
            bad++; $display("FAIL reset_zero: got nonzero state cc=%0d mc=%0d uc=%0d lvl=%0d, need 0",
                            checked_count, mismatch_count, underflow_count, fifo_level);
        end
        total++;
        if (exp_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b need 1", exp_ready); end
    endtask

    task automatic test_basic();
        apply_reset();
        set_live(BASE);
        push_entry(BASE, 8'hFF);
        do_fetch(2);
        total++;
        if (checked_count !== 16'd1) begin bad++; $display("FAIL basic_checked: got %0d need 1", checked_count); end
        total++;
        if (mismatch_count !== 16'd0) begin bad++; $display("FAIL basic_mcnt: got %0d need 0", mismatch_count); end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL basic_pulse: got %0d pulses need 0", pulses); end
        total++;
        if (fifo_level !== 5'd0) begin bad++; $display("FAIL basic_level: got %0d need 0", fifo_level); end
    endtask

    task automatic test_mismatch(input logic [7:0] mask2);
        bit masked;
        masked = (mask2 != 8'hFF);
        apply_reset();
        set_live(BASE);
        push_entry(BASE, 8'hFF);
        push_entry(BASE, mask2);
        push_entry(BASE, 8'hFF);
        do_fetch(2);
        rv[2] = 8'h99;
        do_fetch(2);
        total++;
        if (mismatch_regs !== (masked ? 8'h00 : 8'h04)) begin
            bad++; $display("FAIL mm_regs: got %h need %h", mismatch_regs, masked ? 8'h00 : 8'h04);
        end
        rv[2] = 8'h02;
        do_fetch(2);
        total++;
        if (pulses != (masked ? 0 : 1)) begin bad++; $display("FAIL mm_pulses: got %0d need %0d", pulses, masked ? 0 : 1); end
        total++;
        if (checked_count !== 16'd3) begin bad++; $display("FAIL mm_checked: got %0d need 3", checked_count); end
        total++;
        if (mismatch_count !== (masked ? 16'd0 : 16'd1)) begin
            bad++; $display("FAIL mm_count: got %0d need %0d", mismatch_count, masked ? 0 : 1);
        end
        total++;
        if (first_mismatch_valid !== !masked) begin bad++; $display("FAIL mm_fvalid: got %b need %b", first_mismatch_valid, !masked); end
        if (!masked) begin
            total++;
            if (first_mismatch_index !== 16'd1) begin bad++; $display("FAIL mm_findex: got %0d need 1", first_mismatch_index); end
        end
    endtask

    task automatic test_long_fetch();
        apply_reset();
        set_live(BASE);
        push_entry(BASE, 8'hFF);
        push_entry(BASE, 8'hFF);
        do_fetch(4);
        total++;
        if (fifo_level !== 5'd1) begin bad++; $display("FAIL long_level: got %0d need 1", fifo_level); end
        total++;
        if (checked_count !== 16'd1) begin bad++; $display("FAIL long_checked: got %0d need 1", checked_count); end
    endtask

    task automatic test_underflow_push();
        apply_reset();
        exp_valid = 1'b1; exp_regs = BASE; exp_mask = 8'hFF; state = INSTR_FETCH_START;
        step();
        exp_valid = 1'b0; state = INSTR_DECODE;
        step(); step();
        total++;
        if (underflow_count !== 16'd1) begin bad++; $display("FAIL uf_count: got %0d need 1", underflow_count); end
        total++;
        if (fifo_level !== 5'd1) begin bad++; $display("FAIL uf_level: got %0d need 1", fifo_level); end
        total++;
        if (checked_count !== 16'd0) begin bad++; $display("FAIL uf_checked: got %0d need 0", checked_count); end
    endtask

    task automatic test_full_and_reset();
        apply_reset();
        set_live(BASE);
        exp_valid = 1'b1; exp_mask = 8'hFF;
        for (int i = 0; i < DEPTH; i++) begin
            exp_regs = (i == 0) ? ~BASE : BASE;
            step();
        end
        total++;
        if (exp_ready !== 1'b0 || fifo_level !== 5'd16) begin
            bad++; $display("FAIL full_state: got ready=%b level=%0d need ready=0 level=16", exp_ready, fifo_level);
        end
        step();
        total++;
        if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_drop: got %0d need 16", fifo_level); end
        state = INSTR_FETCH_START;
        step();
        total++;
        if (fifo_level !== 5'd15) begin bad++; $display("FAIL full_pushpop: got %0d need 15", fifo_level); end
        exp_valid = 1'b0;
        reset = 1'b1;
        step();
        total++;
        if ({checked_count, mismatch_count, underflow_count, fifo_level, mismatch, mismatch_regs} !== 63'd0
            || exp_ready !== 1'b1) begin
            bad++; $display("FAIL midreset: got cc=%0d lvl=%0d mm=%b ready=%b need all 0 ready=1",
                            checked_count, fifo_level, mismatch, exp_ready);
        end
        reset = 1'b0; state = INSTR_DECODE;
        step();
        total++;
        if (mismatch !== 1'b0 || checked_count !== 16'd0) begin
            bad++; $display("FAIL midreset_inflight: got mm=%b cc=%0d need 0 0", mismatch, checked_count);
        end
    endtask

    task automatic test_random();
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) != 0);
            state  = ($urandom_range(0, 2) == 0) ? INSTR_FETCH_START : ExecutionStage'(3'($urandom_range(0, 7)));
            for (int i = 0; i < 8; i++) rv[i] = 8'($urandom_range(0, 3));
            exp_valid = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 0) exp_regs = live_regs();
            else for (int i = 0; i < 8; i++) exp_regs[8*i +: 8] = 8'($urandom_range(0, 3));
            exp_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step();
            total++;
            if (checked_count !== m_checked) begin bad++; $display("FAIL rnd_checked c=%0d: got %0d need %0d", c, checked_count, m_checked); end
            total++;
            if (mismatch_count !== m_mcnt) begin bad++; $display("FAIL rnd_mcnt c=%0d: got %0d need %0d", c, mismatch_count, m_mcnt); end
            total++;
            if (underflow_count !== m_under) begin bad++; $display("FAIL rnd_under c=%0d: got %0d need %0d", c, underflow_count, m_under); end
            total++;
            if (fifo_level !== 5'(m_q.size()) || exp_ready !== (m_q.size() != DEPTH)) begin
                bad++; $display("FAIL rnd_level c=%0d: got %0d/%b need %0d", c, fifo_level, exp_ready, m_q.size());
            end
            total++;
            if (mismatch !== m_mis || mismatch_regs !== m_mregs) begin
                bad++; $display("FAIL rnd_mm c=%0d: got %b/%h need %b/%h", c, mismatch, mismatch_regs, m_mis, m_mregs);
            end
            total++;
            if (first_mismatch_valid !== m_fv || first_mismatch_index !== m_fidx) begin
                bad++; $display("FAIL rnd_first c=%0d: got %b/%0d need %b/%0d", c, first_mismatch_valid,
                                first_mismatch_index, m_fv, m_fidx);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; state = INSTR_DECODE;
        exp_valid = 1'b0; exp_regs = 64'h0; exp_mask = 8'h00; pulses = 0;
        for (int i = 0; i < 8; i++) rv[i] = 8'h00;
        test_reset();
        test_basic();
        test_mismatch(8'hFF);
        test_mismatch(8'hFB);
        test_long_fetch();
        test_underflow_push();
        test_full_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
